// File: rtl/stream_bit_permuter.sv
// stream_bit_permuter: two-stage valid/ready pipeline that permutes each word by its tagged mode
//   clk        : clock, all state on rising edge
//   resetn     : asynchronous active-low reset
//   din/mode   : input word and permutation select (0 bit rev, 1 byte rev, 2 per-byte bit rev, 3 pass)
//   din_valid  : producer offers din/mode
//   din_ready  : block accepts a word this cycle
//   dout       : permuted word from stage 2
//   dout_valid : dout holds a result
//   dout_ready : consumer accepts dout
//   out_count  : delivered-word counter, wraps modulo 2^COUNT_WIDTH
module stream_bit_permuter #(
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic [DATA_WIDTH-1:0]  din,
   input  logic [1:0]             mode,
   input  logic                   din_valid,
   output logic                   din_ready,
   output logic [DATA_WIDTH-1:0]  dout,
   output logic                   dout_valid,
   input  logic                   dout_ready,
   output logic [COUNT_WIDTH-1:0] out_count
);
   localparam int NB = DATA_WIDTH / 8;
   logic                   s1_valid_q, s1_valid_d;
   logic [DATA_WIDTH-1:0]  s1_data_q, s1_data_d;
   logic [1:0]             s1_mode_q, s1_mode_d;
   logic                   s2_valid_q, s2_valid_d;
   logic [DATA_WIDTH-1:0]  s2_data_q, s2_data_d;
   logic [COUNT_WIDTH-1:0] count_q, count_d;
   logic                   s2_ready, in_xfer, move, out_xfer;
   logic [DATA_WIDTH-1:0]  bit_rev, byte_rev, byte_bit_rev, perm;
   genvar i, k, j;
   for (i = 0; i < DATA_WIDTH; i = i + 1) begin : g_bit
      assign bit_rev[i] = s1_data_q[DATA_WIDTH-1-i];
   end
   for (k = 0; k < NB; k = k + 1) begin : g_byte
      for (j = 0; j < 8; j = j + 1) begin : g_lane
         assign byte_rev[8*k+j]     = s1_data_q[8*(NB-1-k)+j];
         assign byte_bit_rev[8*k+j] = s1_data_q[8*k+7-j];
      end
   end
   assign perm = s1_mode_q == 2'd0 ? bit_rev :
                 s1_mode_q == 2'd1 ? byte_rev :
                 s1_mode_q == 2'd2 ? byte_bit_rev : s1_data_q;
   // Ready propagates backwards combinationally so a full pipe can still stream
   assign s2_ready  = !s2_valid_q || dout_ready;
   assign din_ready = !s1_valid_q || s2_ready;
   assign in_xfer   = din_valid && din_ready;
   assign move      = s1_valid_q && s2_ready;
   assign out_xfer  = s2_valid_q && dout_ready;
   always_comb begin
      s1_valid_d = in_xfer ? 1'b1 : (move ? 1'b0 : s1_valid_q);
      s1_data_d  = in_xfer ? din : s1_data_q;
      s1_mode_d  = in_xfer ? mode : s1_mode_q;
      s2_valid_d = move ? 1'b1 : (dout_ready ? 1'b0 : s2_valid_q);
      s2_data_d  = move ? perm : s2_data_q;
      count_d    = count_q + COUNT_WIDTH'(out_xfer);
   end
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_mode_q  <= 2'd0;
         s2_valid_q <= 1'b0;
         s2_data_q  <= '0;
         count_q    <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_mode_q  <= s1_mode_d;
         s2_valid_q <= s2_valid_d;
         s2_data_q  <= s2_data_d;
         count_q    <= count_d;
      end
   end
   assign dout       = s2_data_q;
   assign dout_valid = s2_valid_q;
   assign out_count  = count_q;
endmodule

// File: tb/tb_stream_bit_permuter.sv
// tb_stream_bit_permuter: directed and randomized checks of the two-stage bit permuter
module tb_stream_bit_permuter;
   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] din;
   logic [1:0]  mode;
   logic        din_valid;
   logic        din_ready;
   logic [31:0] dout;
   logic        dout_valid;
   logic        dout_ready;
   logic [3:0]  out_count;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   stream_bit_permuter #(.DATA_WIDTH(32), .COUNT_WIDTH(4)) dut (
      .clk(clk), .resetn(resetn), .din(din), .mode(mode), .din_valid(din_valid),
      .din_ready(din_ready), .dout(dout), .dout_valid(dout_valid),
      .dout_ready(dout_ready), .out_count(out_count)
   );
   function automatic logic [31:0] ref_perm(input logic [31:0] d, input logic [1:0] m);
      logic [31:0] r;
      r = d;
      if (m == 2'd0) r = {<<{d}};
      else if (m == 2'd1) r = {<<8{d}};
      else if (m == 2'd2) begin
         for (int b = 0; b < 4; b++) begin
            logic [7:0] x;
            x = d[8*b +: 8];
            r[8*b +: 8] = {<<{x}};
         end
      end
      return r;
   endfunction
   task automatic test_reset;
      resetn = 1'b0; din = '0; mode = 2'd0; din_valid = 1'b0; dout_ready = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
      checks++; if (dout !== 32'h0) begin errors++; $display("FAIL reset_dout got %h exp 0", dout); end
      checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", out_count); end
      checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", din_ready); end
      resetn = 1'b1;
   endtask
   task automatic test_mode0;
      din = 32'h1; mode = 2'd0; din_valid = 1'b1; dout_ready = 1'b1;
      @(negedge clk);
      checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL m0_latency got %b exp 0", dout_valid); end
      din = 32'h12345678;
      @(negedge clk);
      din_valid = 1'b0;
      checks++; if (dout_valid !== 1'b1 || dout !== 32'h80000000) begin errors++; $display("FAIL m0_first got %b/%h exp 1/80000000", dout_valid, dout); end
      @(negedge clk);
      checks++; if (dout_valid !== 1'b1 || dout !== 32'h1E6A2C48) begin errors++; $display("FAIL m0_second got %b/%h exp 1/1e6a2c48", dout_valid, dout); end
      @(negedge clk);
      checks++; if (dout_valid !== 1'b0 || out_count !== 4'd2) begin errors++; $display("FAIL m0_count got %b/%0d exp 0/2", dout_valid, out_count); end
   endtask
   task automatic test_back_to_back;
      logic [31:0] wd [4];
      logic [1:0]  wm [4];
      logic [31:0] we [4];
      wd[0] = 32'h12345678; wm[0] = 2'd1; we[0] = 32'h78563412;
      wd[1] = 32'h01020304; wm[1] = 2'd2; we[1] = 32'h8040C020;
      wd[2] = 32'hDEADBEEF; wm[2] = 2'd3; we[2] = 32'hDEADBEEF;
      wd[3] = 32'h00000001; wm[3] = 2'd0; we[3] = 32'h80000000;
      dout_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c >= 2) begin
            checks++; if (dout_valid !== 1'b1 || dout !== we[c-2]) begin errors++; $display("FAIL b2b_word%0d got %b/%h exp 1/%h", c-2, dout_valid, dout, we[c-2]); end
         end
         if (c < 4) begin din = wd[c]; mode = wm[c]; din_valid = 1'b1; end
         else din_valid = 1'b0;
         #1;
         checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b exp 1", c, din_ready); end
         @(negedge clk);
      end
      checks++; if (dout_valid !== 1'b0 || out_count !== 4'd6) begin errors++; $display("FAIL b2b_count got %b/%0d exp 0/6", dout_valid, out_count); end
   endtask
   task automatic test_backpressure;
      dout_ready = 1'b0; din = 32'h1; mode = 2'd3; din_valid = 1'b1;
      @(negedge clk);
      din = 32'h2;
      @(negedge clk);
      din = 32'h3;
      #1;
      checks++; if (din_ready !== 1'b0 || dout_valid !== 1'b1 || dout !== 32'h1) begin errors++; $display("FAIL bp_full got %b/%b/%h exp 0/1/00000001", din_ready, dout_valid, dout); end
      repeat (3) begin
         @(negedge clk);
         checks++; if (din_ready !== 1'b0 || dout !== 32'h1) begin errors++; $display("FAIL bp_hold got %b/%h exp 0/00000001", din_ready, dout); end
      end
      dout_ready = 1'b1;
      #1;
      checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %b exp 1", din_ready); end
      @(negedge clk);
      din_valid = 1'b0;
      checks++; if (dout_valid !== 1'b1 || dout !== 32'h2) begin errors++; $display("FAIL bp_B got %b/%h exp 1/00000002", dout_valid, dout); end
      @(negedge clk);
      checks++; if (dout_valid !== 1'b1 || dout !== 32'h3) begin errors++; $display("FAIL bp_C got %b/%h exp 1/00000003", dout_valid, dout); end
      @(negedge clk);
      checks++; if (dout_valid !== 1'b0 || out_count !== 4'd9) begin errors++; $display("FAIL bp_count got %b/%0d exp 0/9", dout_valid, out_count); end
   endtask
   task automatic test_reset_mid;
      dout_ready = 1'b0; din = 32'hAAAA5555; mode = 2'd3; din_valid = 1'b1;
      @(negedge clk);
      din = 32'h0F0F0F0F;
      @(negedge clk);
      din_valid = 1'b0;
      checks++; if (dout_valid !== 1'b1 || din_ready !== 1'b0) begin errors++; $display("FAIL rm_loaded got %b/%b exp 1/0", dout_valid, din_ready); end
      resetn = 1'b0;
      #1;
      checks++; if (dout_valid !== 1'b0 || dout !== 32'h0) begin errors++; $display("FAIL rm_out got %b/%h exp 0/00000000", dout_valid, dout); end
      checks++; if (out_count !== 4'd0 || din_ready !== 1'b1) begin errors++; $display("FAIL rm_state got %0d/%b exp 0/1", out_count, din_ready); end
      @(negedge clk);
      resetn = 1'b1; dout_ready = 1'b1;
      repeat (4) begin
         @(negedge clk);
         checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rm_ghost got %b/%h exp 0", dout_valid, dout); end
      end
      din = 32'h00FF00FF; mode = 2'd1; din_valid = 1'b1;
      @(negedge clk);
      din_valid = 1'b0;
      @(negedge clk);
      checks++; if (dout_valid !== 1'b1 || dout !== 32'hFF00FF00) begin errors++; $display("FAIL rm_after got %b/%h exp 1/ff00ff00", dout_valid, dout); end
      @(negedge clk);
      checks++; if (dout_valid !== 1'b0 || out_count !== 4'd1) begin errors++; $display("FAIL rm_count got %b/%0d exp 0/1", dout_valid, out_count); end
   endtask
   task automatic test_wrap;
      resetn = 1'b0; din_valid = 1'b0;
      @(negedge clk);
      resetn = 1'b1; dout_ready = 1'b1; mode = 2'd3;
      for (int c = 0; c < 20; c++) begin
         logic [3:0] ec;
         ec = 4'((c >= 2) ? c - 2 : 0);
         checks++; if (out_count !== ec) begin errors++; $display("FAIL wrap_count%0d got %0d exp %0d", c, out_count, ec); end
         if (c >= 2 && c <= 18) begin
            checks++; if (dout_valid !== 1'b1 || dout !== 32'(c - 2)) begin errors++; $display("FAIL wrap_word%0d got %b/%h exp 1/%h", c-2, dout_valid, dout, 32'(c - 2)); end
         end
         if (c == 19) begin
            checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL wrap_drain got %b exp 0", dout_valid); end
         end
         if (c < 17) begin din = 32'(c); din_valid = 1'b1; end
         else din_valid = 1'b0;
         @(negedge clk);
      end
   endtask
   task automatic test_random;
      logic [31:0] q [$];
      logic [31:0] prev_dout;
      logic        prev_stall;
      logic        held;
      int          sent;
      int          delivered;
      int          cyc;
      sent = 0; delivered = 0; cyc = 0; prev_stall = 1'b0; held = 1'b0; prev_dout = '0;
      din_valid = 1'b0;
      while ((sent < 10000 || q.size() != 0) && cyc < 60000) begin
         if (prev_stall) begin
            checks++; if (dout_valid !== 1'b1 || dout !== prev_dout) begin errors++; $display("FAIL rnd_stable got %b/%h exp 1/%h", dout_valid, dout, prev_dout); end
         end
         if (!held) begin
            if (sent < 10000) begin
               din_valid = ($urandom_range(0, 9) < 7);
               din = $urandom;
               mode = 2'($urandom_range(0, 3));
            end else din_valid = 1'b0;
         end
         dout_ready = ($urandom_range(0, 9) < 7);
         #1;
         if (dout_valid && dout_ready) begin
            checks++;
            if (q.size() == 0) begin errors++; $display("FAIL rnd_extra got %h exp none", dout); end
            else begin
               if (dout !== q[0]) begin errors++; $display("FAIL rnd_data got %h exp %h", dout, q[0]); end
               void'(q.pop_front());
            end
            delivered++;
         end
         if (din_valid && din_ready) begin
            q.push_back(ref_perm(din, mode));
            sent++;
         end
         held = din_valid && !din_ready;
         prev_stall = dout_valid && !dout_ready;
         prev_dout = dout;
         cyc++;
         @(negedge clk);
      end
      din_valid = 1'b0;
      checks++; if (cyc >= 60000) begin errors++; $display("FAIL rnd_timeout got %0d pending exp 0", q.size()); end
      checks++; if (out_count !== 4'(1 + delivered)) begin errors++; $display("FAIL rnd_count got %0d exp %0d", out_count, 4'(1 + delivered)); end
   endtask
   initial begin
      test_reset;
      test_mode0;
      test_back_to_back;
      test_backpressure;
      test_reset_mid;
      test_wrap;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/stream_bit_permuter.md
# stream_bit_permuter

Pipelined, handshaked successor to the combinational bit reverser. Accepts a stream of `DATA_WIDTH`-bit words, each tagged with a 2-bit permutation mode:
- full bit reverse
- byte reverse (endian swap)
- bit reverse within each byte
- pass-through

Each word's result is delivered through a two-stage valid/ready pipeline with full throughput under backpressure. The block sits between a producer and consumer stream and also counts delivered words.

## Interface
- `DATA_WIDTH`, 32, word width; must be a multiple of 8 and ≥ 8.
- `COUNT_WIDTH`, 16, width of the delivered-word counter.

- `clk`  in  1  single clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `din`  in  `DATA_WIDTH`  input word.
- `mode`  in  2  permutation select, travels with `din`: 0 bit reverse, 1 byte reverse, 2 per-byte bit reverse, 3 pass-through.
- `din_valid`  in  1  producer has a word on `din`/`mode`.
- `din_ready`  out  1  block can accept a word this cycle.
- `dout`  out  `DATA_WIDTH`  permuted word.
- `dout_valid`  out  1  `dout` holds a valid result.
- `dout_ready`  in  1  consumer accepts `dout` this cycle.
- `out_count`  out  `COUNT_WIDTH`  number of words delivered, modulo 2^`COUNT_WIDTH`.

## Operation
- Transfer occurs on a rising edge where valid and ready are both high, on either side.
- Stage 1 (S1) registers `din` and `mode` on input transfer.
- Stage 2 (S2) registers the permuted S1 word; its outputs are `dout` and `dout_valid`.
- Permutation, with W = `DATA_WIDTH` and B = W/8:
  - mode 0: `out[i] = in[W-1-i]`.
  - mode 1: `out[8k+j] = in[8(B-1-k)+j]`.
  - mode 2: `out[8k+j] = in[8k+7-j]`.
  - mode 3: `out = in`.
- Mode is captured per word. Changing `mode` while a word is held off by `din_ready`=0 is a protocol violation; the block samples `mode` only at transfer.
- Ready chain:
  - `s2_ready = !dout_valid || dout_ready`.
  - `din_ready = !s1_valid || s2_ready`.
  - Combinational from `dout_ready` is permitted.
- S1→S2 move happens when `s1_valid && s2_ready`. S1 then reloads in the same edge if an input transfer also occurs; otherwise `s1_valid` clears.
- S2 loads on S1→S2 move. If `dout_ready` is high and no move occurs, `dout_valid` clears. Otherwise `dout` and `dout_valid` hold stable.
- While `dout_valid`=1 and `dout_ready`=0, `dout` is stable.
- `out_count` increments by 1 on each output transfer and wraps from 2^`COUNT_WIDTH`−1 to 0.
- No reordering, duplication or loss of words. Capacity is 2 words.

## Timing
- Reset (`resetn`=0, asynchronous) forces:
  - `s1_valid`=0, `dout_valid`=0.
  - `dout`=0, `out_count`=0.
  - `din_ready`=1 combinationally once `resetn`=0 has propagated.
- Reset mid-stream discards both stored words. The first word after release is handled normally.
- Deassertion is synchronous to `clk` in the surrounding design. The block accepts on the first edge with `resetn`=1.
- Latency: a word accepted at edge N is presented with `dout_valid`=1 in the cycle after edge N+1 (2 edges), if unstalled.
- Throughput: 1 word/cycle sustained when `dout_ready`=1 constantly.
- Full condition: both stages valid and `dout_ready`=0 gives `din_ready`=0.
- Simultaneous input and output transfer while full is legal. It keeps occupancy at 2 in the same cycle.
- Empty condition: `dout_valid`=0 and `din_ready`=1.

## Test plan
- Mode 0, `din`=0x00000001 then 0x12345678, `dout_ready`=1 → `dout`=0x80000000 then 0x1E6A2C48, 2 edges after each accept; `out_count`=2.
- Mode 1, `din`=0x12345678 → 0x78563412. Mode 2, `din`=0x01020304 → 0x8040C020. Mode 3, `din`=0xDEADBEEF → 0xDEADBEEF. Modes interleaved back-to-back at 1 word/cycle with no bubbles.
- Backpressure: `dout_ready`=0, offer A=0x1, B=0x2, C=0x3 (mode 3) → A and B accepted, `din_ready`=0 holding C, `dout`=0x1 stable. Raise `dout_ready` → outputs 0x1, 0x2, 0x3 in order on consecutive cycles.
- Reset mid-operation: two words in flight, `resetn` low for 1 cycle → `dout_valid`=0, `out_count`=0, `din_ready`=1 immediately. Neither stored word ever appears.
- Counter wrap with `COUNT_WIDTH`=4: deliver 17 words → `out_count` reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
- Random valid/ready toggling, 10k words, all modes, with a scoreboard reference model → exact in-order match; `dout` is never changed while stalled.
